// File: rtl/io_mmio_responder_pkg.sv
// Shared constants for the MMIO responder: register offsets, CTRL bit positions and IO region tag.
package io_mmio_pkg;
    localparam logic [7:0] ADR_CTRL    = 8'h00;
    localparam logic [7:0] ADR_RXDATA  = 8'h04;
    localparam logic [7:0] ADR_TXDATA  = 8'h08;
    localparam logic [7:0] ADR_CYCLES  = 8'h10;
    localparam logic [7:0] ADR_INSTS   = 8'h14;
    localparam logic [7:0] ADR_CNT_RST = 8'h18;

    localparam int CTRL_TX_EMPTY    = 0;
    localparam int CTRL_RX_NONEMPTY = 1;
    localparam int CTRL_TX_OVF      = 2;

    // Upper address nibble of the IO region; selection happens upstream of this block.
    localparam logic [3:0] IO_REGION = 4'b1000;
endpackage

// File: rtl/io_mmio_responder_if.sv
// Core-side MMIO bus plus UART valid/ready links, bundled for the responder.
interface io_mmio_responder_if;
    logic [31:0] io_adr;
    logic [31:0] io_wdata;
    logic        iowea;
    logic        io_rd_en;
    logic        inst_retire;
    logic [31:0] io_rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    modport slave (
        input  io_adr, io_wdata, iowea, io_rd_en, inst_retire, uart_tx_ready,
               uart_rx_data, uart_rx_valid,
        output io_rdata, uart_tx_data, uart_tx_valid, uart_rx_ready
    );
    modport master (
        output io_adr, io_wdata, iowea, io_rd_en, inst_retire, uart_tx_ready,
               uart_rx_data, uart_rx_valid,
        input  io_rdata, uart_tx_data, uart_tx_valid, uart_rx_ready
    );
endinterface

// File: rtl/io_mmio_responder_rx_fifo.sv
// Synchronous byte FIFO buffering UART RX data until the core reads it.
module io_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/io_mmio_responder.sv
// MMIO responder: CTRL/status, UART TX holding register, RX FIFO and cycle/instret counters,
// with load data registered for the writeback stage.
module io_mmio_responder
    import io_mmio_pkg::*;
#(
    parameter int RX_DEPTH = 4,
    parameter int CNT_W    = 32
) (
    input logic                clk,
    input logic                rst,
    io_mmio_responder_if.slave bus
);
    logic [7:0]       w_adr;
    logic             w_rd;
    logic             w_wr;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic [7:0]       w_rx_head;
    logic             w_rx_push;
    logic             w_rx_pop;
    logic             w_tx_hs;
    logic [31:0]      w_ctrl;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    logic [31:0]      r_rdata;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid;
    logic             r_tx_ovf;
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] r_insts;

    assign w_adr    = bus.io_adr[7:0];
    assign w_rd     = bus.io_rd_en;
    assign w_wr     = bus.iowea;
    assign w_unused = ^{bus.io_adr[31:8], bus.io_wdata[31:8]};

    assign w_rx_push = bus.uart_rx_valid && !w_rx_full;
    assign w_rx_pop  = w_rd && (w_adr == ADR_RXDATA) && !w_rx_empty;

    io_rx_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_data  (bus.uart_rx_data),
        .i_pop   (w_rx_pop),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    assign bus.uart_rx_ready = !w_rx_full;
    assign bus.uart_tx_data  = r_tx_data;
    assign bus.uart_tx_valid = r_tx_valid;
    assign bus.io_rdata      = r_rdata;

    always_comb begin
        w_ctrl                   = '0;
        w_ctrl[CTRL_TX_EMPTY]    = !r_tx_valid;
        w_ctrl[CTRL_RX_NONEMPTY] = !w_rx_empty;
        w_ctrl[CTRL_TX_OVF]      = r_tx_ovf;
    end

    // All sources are pre-edge values, so a concurrent store lands after the sample.
    always_comb begin
        w_rd_mux = '0;
        case (w_adr)
            ADR_CTRL:   w_rd_mux = w_ctrl;
            ADR_RXDATA: w_rd_mux = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
            ADR_CYCLES: w_rd_mux = 32'(r_cycles);
            ADR_INSTS:  w_rd_mux = 32'(r_insts);
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_rdata <= '0;
        else if (w_rd) r_rdata <= w_rd_mux;
    end

    // A handshake completing on this edge frees the holding register for a new byte.
    assign w_tx_hs = r_tx_valid && bus.uart_tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_ovf   <= 1'b0;
        end else begin
            if (w_wr && (w_adr == ADR_TXDATA)) begin
                if (!r_tx_valid || w_tx_hs) begin
                    r_tx_data  <= bus.io_wdata[7:0];
                    r_tx_valid <= 1'b1;
                end else begin
                    r_tx_ovf <= 1'b1;
                end
            end else if (w_tx_hs) begin
                r_tx_valid <= 1'b0;
            end
            if (w_wr && (w_adr == ADR_CTRL) && bus.io_wdata[CTRL_TX_OVF])
                r_tx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycles <= '0;
            r_insts  <= '0;
        end else if (w_wr && (w_adr == ADR_CNT_RST)) begin
            r_cycles <= '0;
            r_insts  <= '0;
        end else begin
            r_cycles <= r_cycles + 1'b1;
            if (bus.inst_retire) r_insts <= r_insts + 1'b1;
        end
    end
endmodule
